alu_pwr_seq: RTL and testbench

- Power-sequencing controller directly upstream of the ALU wrapper.
- Generates alu_pwr_en and iso_en with ordered timing: isolate before power-off, power-on before de-isolate.
- Gates the ALU start strobe so operations only issue while the ALU domain is fully on.
- Drains in-flight ALU work before any power-down.

---
 rtl/alu_pwr_pkg.sv | 39 +++
 rtl/alu_pwr_timer.sv | 29 ++
 rtl/alu_pwr_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_pwr_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// rtl/alu_pwr_pkg.sv - shared types and constants for the ALU power sequencer
// Contents: pwr_state_t encoding, state width, default cycle counts, timer width,
//           and the state-to-rail mapping used for the registered power/isolation outputs.
package alu_pwr_pkg;

    localparam int PWR_STATE_W = 3;

    typedef enum logic [PWR_STATE_W-1:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_ON     = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ISO    = 3'd4
    } pwr_state_t;

    localparam int DEF_PWRUP_CYCLES = 8;
    localparam int DEF_ISO_CYCLES   = 2;
    localparam int DEF_IDLE_TIMEOUT = 64;

    // Both timed phases accept 1..255 cycles, so an 8-bit down-counter covers them.
    localparam int TIMER_W = 8;

    // Returns {alu_pwr_en, iso_en} for a state. Isolation stays up in every state
    // where the domain is not fully usable, which keeps iso high whenever power is off.
    function automatic logic [1:0] rail_of(input pwr_state_t s);
        logic [1:0] r;
        r = 2'b01;
        case (s)
            ST_OFF:    r = 2'b01;
            ST_PWR_UP: r = 2'b11;
            ST_ON:     r = 2'b10;
            ST_DRAIN:  r = 2'b10;
            ST_ISO:    r = 2'b11;
            default:   r = 2'b01;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// rtl/alu_pwr_timer.sv - loadable down-counter with zero flag for sequencer phase timing
// Ports: clk, rst_n (async active-low), load (strobe), load_val (count to load),
//        dec (decrement enable, saturates at zero), zero (count equals zero).
module alu_pwr_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// rtl/alu_pwr_seq.sv - ALU power sequencer: ordered power/isolation control and start gating
// Optional feature macro: ALU_AUTO_SLEEP_EN (idle auto-sleep after IDLE_TIMEOUT cycles in ON).
// Ports: clk, rst_n (async active-low); wake_req, sleep_req (level requests);
//        alu_busy (ALU busy flag); start_in (issuer strobe); start_out (gated strobe);
//        start_drop (registered refused-start pulse); alu_pwr_en, iso_en (domain rails);
//        alu_ready (high in ON); pwr_state (current state encoding).
module alu_pwr_seq
    import alu_pwr_pkg::*;
#(
    parameter int PWRUP_CYCLES = DEF_PWRUP_CYCLES,
    parameter int ISO_CYCLES   = DEF_ISO_CYCLES,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wake_req,
    input  logic                   sleep_req,
    input  logic                   alu_busy,
    input  logic                   start_in,
    output logic                   start_out,
    output logic                   start_drop,
    output logic                   alu_pwr_en,
    output logic                   iso_en,
    output logic                   alu_ready,
    output logic [PWR_STATE_W-1:0] pwr_state
);

    localparam logic [TIMER_W-1:0] PWRUP_LOAD = TIMER_W'(PWRUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ISO_LOAD   = TIMER_W'(ISO_CYCLES - 1);

    if (PWRUP_CYCLES < 1 || PWRUP_CYCLES > 255) begin : g_bad_pwrup
        $error("PWRUP_CYCLES out of range 1..255");
    end
    if (ISO_CYCLES < 1 || ISO_CYCLES > 255) begin : g_bad_iso
        $error("ISO_CYCLES out of range 1..255");
    end
    if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_idle
        $error("IDLE_TIMEOUT out of range 1..65535");
    end

    pwr_state_t         state;
    pwr_state_t         state_nxt;
    logic               pend_wake;
    logic               pend_sleep;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_dec;
    logic               tmr_zero;
    logic               auto_trip;

    alu_pwr_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // The timer is loaded with N-1 on phase entry and the phase exits on the cycle
    // it reads zero, so each timed phase occupies exactly N cycles.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state)
            ST_OFF: begin
                if (wake_req || pend_wake) begin
                    state_nxt = ST_PWR_UP;
                    tmr_load  = 1'b1;
                    tmr_val   = PWRUP_LOAD;
                end
            end
            ST_PWR_UP: begin
                if (tmr_zero) state_nxt = ST_ON;
                else          tmr_dec   = 1'b1;
            end
            ST_ON: begin
                // Wake wins over sleep so a live requester never loses the ALU.
                if ((sleep_req || pend_sleep) && !wake_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wake_req) begin
                    state_nxt = ST_ON;
                end else if (!alu_busy) begin
                    state_nxt = ST_ISO;
                    tmr_load  = 1'b1;
                    tmr_val   = ISO_LOAD;
                end
            end
            ST_ISO: begin
                if (tmr_zero) state_nxt = ST_OFF;
                else          tmr_dec   = 1'b1;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // No new work once a power-down is requested, even before DRAIN is reached.
    assign start_out = start_in && (state == ST_ON) && !(sleep_req || pend_sleep);
    assign pwr_state = state;

`ifdef ALU_AUTO_SLEEP_EN
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);

    logic [15:0] idle_cnt;
    logic        idle_run;
    logic        activity;

    assign activity  = start_in || alu_busy || wake_req;
    assign idle_run  = (state == ST_ON) && (state_nxt == ST_ON) && !activity;
    assign auto_trip = idle_run && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!idle_run || auto_trip) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign auto_trip = 1'b0;
`endif

    // Outputs are registered from the next state so they change on the same edge
    // as the state register and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
            alu_ready  <= 1'b0;
            start_drop <= 1'b0;
            pend_wake  <= 1'b0;
            pend_sleep <= 1'b0;
        end else begin
            state                <= state_nxt;
            {alu_pwr_en, iso_en} <= rail_of(state_nxt);
            alu_ready            <= (state_nxt == ST_ON);
            start_drop           <= start_in && !start_out;

            // A wake seen while isolating is remembered so OFF re-powers at once.
            if (state == ST_OFF && state_nxt == ST_PWR_UP) begin
                pend_wake <= 1'b0;
            end else if (state == ST_ISO && wake_req) begin
                pend_wake <= 1'b1;
            end

            // A sleep seen while powering up is honoured on the first ON cycle.
            if (state == ST_ON && state_nxt != ST_ON) begin
                pend_sleep <= 1'b0;
            end else if (state == ST_PWR_UP && sleep_req) begin
                pend_sleep <= 1'b1;
            end else if (auto_trip) begin
                pend_sleep <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_pwr_seq.sv
// tb/tb_alu_pwr_seq.sv - self-checking bench for alu_pwr_seq with a behavioural reference model
module tb_alu_pwr_seq;

    localparam int PWRUP = 8;
    localparam int ISOC  = 2;
    localparam int IDLE  = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wake_req, sleep_req, alu_busy, start_in;
    logic       start_out, start_drop, alu_pwr_en, iso_en, alu_ready;
    logic [2:0] pwr_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: state number, cycles remaining in a timed phase, pending flags, idle count.
    int m_state, m_left, m_idle;
    bit m_pw, m_ps, m_drop;

    alu_pwr_seq #(
        .PWRUP_CYCLES (PWRUP),
        .ISO_CYCLES   (ISOC),
        .IDLE_TIMEOUT (IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wake_req   (wake_req),
        .sleep_req  (sleep_req),
        .alu_busy   (alu_busy),
        .start_in   (start_in),
        .start_out  (start_out),
        .start_drop (start_drop),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .alu_ready  (alu_ready),
        .pwr_state  (pwr_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_left = 0; m_idle = 0;
        m_pw = 0; m_ps = 0; m_drop = 0;
    endtask

    // Model advance for one clock edge, from the state rules: OFF=0 PWR_UP=1 ON=2 DRAIN=3 ISO=4.
    task automatic model_step(input bit w, input bit s, input bit b, input bit st);
        m_drop = st && !(m_state == 2 && !(s || m_ps));
        case (m_state)
            0: if (w || m_pw) begin m_state = 1; m_left = PWRUP; m_pw = 0; end
            1: begin
                if (s) m_ps = 1;
                m_left--;
                if (m_left == 0) m_state = 2;
            end
            2: begin
                if ((s || m_ps) && !w) begin
                    m_state = 3; m_ps = 0; m_idle = 0;
                end else begin
`ifdef ALU_AUTO_SLEEP_EN
                    if (st || b || w) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == IDLE) begin m_ps = 1; m_idle = 0; end
                    end
`endif
                end
            end
            3: if (w) m_state = 2;
               else if (!b) begin m_state = 4; m_left = ISOC; end
            4: begin
                if (w) m_pw = 1;
                m_left--;
                if (m_left == 0) m_state = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_outputs(input bit s, input bit st);
        bit exp_pwr, exp_iso, exp_so;
        exp_pwr = (m_state != 0);
        exp_iso = (m_state == 0 || m_state == 1 || m_state == 4);
        exp_so  = st && (m_state == 2) && !(s || m_ps);
        chk("pwr_state",  32'(pwr_state),  32'(m_state));
        chk("alu_pwr_en", 32'(alu_pwr_en), 32'(exp_pwr));
        chk("iso_en",     32'(iso_en),     32'(exp_iso));
        chk("alu_ready",  32'(alu_ready),  32'(m_state == 2));
        chk("start_drop", 32'(start_drop), 32'(m_drop));
        chk("start_out",  32'(start_out),  32'(exp_so));
        chk("rail_order", 32'(!alu_pwr_en && !iso_en), 32'd0);
    endtask

    // One cycle: drive inputs just after the edge, compare at the falling edge, advance model.
    task automatic step(input bit w, input bit s, input bit b, input bit st);
        wake_req = w; sleep_req = s; alu_busy = b; start_in = st;
        @(negedge clk);
        check_outputs(s, st);
        @(posedge clk);
        model_step(w, s, b, st);
        #1;
    endtask

    task automatic wait_state(input int tgt, input int max_cycles);
        int n = 0;
        while (32'(pwr_state) != tgt && n < max_cycles) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("wait_state", 32'(pwr_state), 32'(tgt));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        wake_req = 0; sleep_req = 0; alu_busy = 0; start_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_state", 32'(pwr_state), 32'd0);
        chk("reset_pwr",   32'(alu_pwr_en), 32'd0);
        chk("reset_iso",   32'(iso_en), 32'd1);
        chk("reset_ready", 32'(alu_ready), 32'd0);
        chk("reset_drop",  32'(start_drop), 32'd0);

        // One-cycle wake pulse: power rises next edge, isolation drops PWRUP cycles later.
        step(1, 0, 0, 0);
        chk("pwrup_pwr",   32'(alu_pwr_en), 32'd1);
        chk("pwrup_state", 32'(pwr_state), 32'd1);
        n = 0;
        while (iso_en && n < 50) begin step(0, 0, 0, 0); n++; end
        chk("pwrup_len",  32'(n), 32'd8);
        chk("on_ready",   32'(alu_ready), 32'd1);
        chk("on_state",   32'(pwr_state), 32'd2);

        // Sleep while busy: start refused, DRAIN holds until busy drops.
        step(0, 1, 1, 1);
        chk("drain_state", 32'(pwr_state), 32'd3);
        chk("drop_pulse",  32'(start_drop), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0);
            chk("drain_hold", 32'(pwr_state), 32'd3);
        end
        chk("drop_one_cycle", 32'(start_drop), 32'd0);
        step(0, 1, 0, 0);
        chk("iso_state", 32'(pwr_state), 32'd4);
        chk("iso_up",    32'(iso_en), 32'd1);
        n = 0;
        while (alu_pwr_en && n < 20) begin step(0, 0, 0, 0); n++; end
        chk("iso_len",   32'(n), 32'd2);
        chk("off_state", 32'(pwr_state), 32'd0);
        chk("off_iso",   32'(iso_en), 32'd1);

        // Wake priority in ON, and wake aborting a drain.
        step(1, 0, 0, 0);
        wait_state(2, 20);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            chk("wake_prio", 32'(pwr_state), 32'd2);
        end
        step(0, 1, 1, 0);
        chk("drain_enter", 32'(pwr_state), 32'd3);
        step(1, 1, 1, 0);
        chk("drain_abort", 32'(pwr_state), 32'd2);
        chk("abort_iso",   32'(iso_en), 32'd0);

        // Wake during ISO: one OFF cycle, then straight back to PWR_UP.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("iso_again", 32'(pwr_state), 32'd4);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pend_wake_off", 32'(pwr_state), 32'd0);
        step(0, 0, 0, 0);
        chk("pend_wake_up",  32'(pwr_state), 32'd1);

        // Sleep during PWR_UP: exactly one ON cycle, then DRAIN.
        step(0, 1, 0, 0);
        wait_state(2, 20);
        step(0, 0, 0, 0);
        chk("pend_sleep_drain", 32'(pwr_state), 32'd3);
        wait_state(0, 20);

        // Asynchronous reset in the middle of PWR_UP.
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwr",   32'(alu_pwr_en), 32'd0);
        chk("async_iso",   32'(iso_en), 32'd1);
        chk("async_state", 32'(pwr_state), 32'd0);
        chk("async_ready", 32'(alu_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
